xtrig_cycle_scheduler: RTL and testbench
========================================

Name: xtrig_cycle_scheduler

Overview:
Upstream sequencer for the laser/DLP/XTRIG controller. It issues xtrig cycle start pulses from a software trigger or a programmed period, and spaces them by a fixed period. It tracks each cycle through the controller's done flag (high = idle), counts issued cycles, and flags a stalled controller with a timeout. Its output drives the controller's xtrig_cycle_start_i; the controller's xtrig_cycle_done_o feeds back in.

Parameters:
CNT_W, 32, width of period/timeout counters and their config inputs
START_PULSE_W, 4, cycles xtrig_cycle_start_o is held high (>=1)
NCYC_W, 16, width of cycle count config and status

Ports:
ctrl_clk_i  in  1  control clock
ctrl_rst_n_i  in  1  reset; asynchronous, active-low
sched_enable_i  in  1  level; 0 = no new launches
mode_i  in  1  0 = software single-shot, 1 = periodic burst
sw_trigger_i  in  1  single-cycle launch request (synchronous)
period_i  in  CNT_W  clocks between consecutive start rising edges (periodic mode)
num_cycles_i  in  NCYC_W  cycles per burst; 0 = unlimited
timeout_i  in  CNT_W  max clocks from start edge to done; 0 = timeout disabled
cycle_done_i  in  1  controller idle flag (1 = idle/done)
err_clr_i  in  1  single-cycle clear of timeout_err_o
xtrig_cycle_start_o  out  1  start pulse to controller
busy_o  out  1  high in any state except IDLE
cycles_issued_o  out  NCYC_W  start pulses issued in current burst
timeout_err_o  out  1  sticky timeout flag
state_o  out  3  current state, debug

Behaviour:
- Reset values: all outputs 0; state IDLE; all counters 0.
- States: IDLE=0, START=1, WAIT_ACK=2, WAIT_DONE=3, GAP=4. Codes 5-7 return to IDLE on the next clock.
- IDLE -> START:
  - Condition: sched_enable_i=1 and sw_trigger_i=1 and cycle_done_i=1.
  - A trigger with cycle_done_i=0 is ignored (not queued).
  - On this transition cycles_issued_o clears to 0.
- Start pulse timing:
  - Trigger at edge t -> xtrig_cycle_start_o=1 from edge t+1 for exactly START_PULSE_W cycles.
  - Registered output, glitch-free.
  - cycles_issued_o increments on the first START cycle and saturates at all-ones.
- Counters on each START entry:
  - Period counter reloads to 1 and then increments every clock, saturating.
  - Timeout counter reloads to 0 and increments in START, WAIT_ACK and WAIT_DONE.
- START -> WAIT_ACK after the pulse width completes.
- WAIT_ACK -> WAIT_DONE when cycle_done_i=0 (controller accepted).
- WAIT_DONE -> GAP when cycle_done_i=1.
- Timeout: if timeout_i!=0 and the timeout counter reaches timeout_i in START/WAIT_ACK/WAIT_DONE:
  - timeout_err_o <= 1;
  - state -> IDLE;
  - the start pulse is truncated if still active.
  - Timeout takes priority over the done/ack transition in the same cycle.
- GAP exits:
  - -> IDLE if mode_i=0, or sched_enable_i=0, or (num_cycles_i!=0 and cycles_issued_o>=num_cycles_i).
  - Otherwise -> START when period counter >= period_i.
  - period_i <= time already elapsed gives back-to-back cycles: START re-entered on the clock after GAP entry.
  - period_i=0 behaves the same way.
- sched_enable_i deasserted mid-cycle: the current cycle completes normally (pulse width, done wait), then GAP -> IDLE. No new pulse is issued.
- timeout_err_o:
  - Set has priority over err_clr_i in the same cycle.
  - While set, IDLE accepts triggers (the error is informational only).
- Config inputs are sampled live; software changes them only while busy_o=0.
- Asynchronous reset mid-operation: start pulse drops immediately, state IDLE, all status cleared.

Optional Feature:
Macro XTRIG_SCHED_EXT_TRIG_EN.
- When defined:
  - Adds input ext_trigger_i (asynchronous), with a 2-flop synchroniser plus rising-edge detect.
  - A detected edge is OR'ed with sw_trigger_i as the IDLE launch request.
  - Adds status output ext_trig_drop_o: a sticky flag, set when an ext edge arrives while busy_o=1, cleared by err_clr_i.
  - Edge latency is 3 clocks from the pin to the start pulse.
- When undefined: neither port exists; behaviour is identical to the above with sw_trigger_i as the only launch source.

Test Plan:
- Single-shot: mode_i=0, START_PULSE_W=4, sw_trigger_i at cycle 10 with cycle_done_i=1 -> start high in cycles 11-14. Model drops done at 16 and raises it at 40 -> IDLE by cycle 42, cycles_issued_o=1, busy_o low.
- Periodic burst: mode_i=1, period_i=100, num_cycles_i=3, model done period 50 -> start rising edges exactly 100 clocks apart, 3 pulses, then IDLE, cycles_issued_o=3.
- Back-to-back: period_i=10, controller done takes 60 clocks -> next START one clock after GAP entry, no pulse while cycle_done_i=0.
- Timeout: timeout_i=200, model never raises done -> timeout_err_o=1 at 200 clocks after start edge, state IDLE. A later err_clr_i clears it; a simultaneous set+clear leaves it 1.
- Disable mid-burst: num_cycles_i=0, period_i=80, deassert sched_enable_i during the 2nd WAIT_DONE -> the 2nd cycle completes, no 3rd pulse, IDLE. A trigger with cycle_done_i=0 in IDLE is ignored.
- Reset mid-START: assert ctrl_rst_n_i low in the 2nd pulse cycle -> xtrig_cycle_start_o drops asynchronously, all outputs 0. After release, a trigger produces a full 4-cycle pulse.

Source files
------------

// File: rtl/xtrig_cycle_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : xtrig_cycle_scheduler
// Description : Upstream sequencer for the laser/DLP/XTRIG controller. Issues
//               xtrig cycle start pulses from a software trigger (single-shot)
//               or as a periodic burst. Each cycle is followed through the
//               controller's done flag (high = idle). A stalled controller is
//               reported by a sticky timeout flag.
//
// Ports       : ctrl_clk_i / ctrl_rst_n_i   clock, async active-low reset
//               sched_enable_i              0 = no new launches
//               mode_i                      0 = single-shot, 1 = periodic burst
//               sw_trigger_i                one-cycle launch request
//               period_i                    clocks between start rising edges
//               num_cycles_i                cycles per burst (0 = unlimited)
//               timeout_i                   start-to-done limit (0 = off)
//               cycle_done_i                controller idle flag
//               err_clr_i                   clears timeout_err_o
//               xtrig_cycle_start_o         registered start pulse
//               busy_o                      state is not IDLE
//               cycles_issued_o             pulses issued in current burst
//               timeout_err_o               sticky timeout flag
//               state_o                     current state (debug)
//
// Optional    : XTRIG_SCHED_EXT_TRIG_EN adds ext_trigger_i (async pin,
//               synchronised, rising-edge detected, OR'ed with sw_trigger_i)
//               and the sticky ext_trig_drop_o flag (edge seen while busy).
//
// Revision    : 1.0 - initial release
// ============================================================================
module xtrig_cycle_scheduler #(
    parameter int CNT_W         = 32,
    parameter int START_PULSE_W = 4,
    parameter int NCYC_W        = 16
) (
    input  logic              ctrl_clk_i,
    input  logic              ctrl_rst_n_i,
    input  logic              sched_enable_i,
    input  logic              mode_i,
    input  logic              sw_trigger_i,
    input  logic [CNT_W-1:0]  period_i,
    input  logic [NCYC_W-1:0] num_cycles_i,
    input  logic [CNT_W-1:0]  timeout_i,
    input  logic              cycle_done_i,
    input  logic              err_clr_i,
`ifdef XTRIG_SCHED_EXT_TRIG_EN
    input  logic              ext_trigger_i,
    output logic              ext_trig_drop_o,
`endif
    output logic              xtrig_cycle_start_o,
    output logic              busy_o,
    output logic [NCYC_W-1:0] cycles_issued_o,
    output logic              timeout_err_o,
    output logic [2:0]        state_o
);

    localparam int PW_W = $clog2(START_PULSE_W + 1);
    localparam logic [PW_W-1:0] LAST_PULSE = PW_W'(START_PULSE_W - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_WAIT_ACK  = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_GAP       = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [PW_W-1:0]   pulse_cnt_q, pulse_cnt_d;
    logic [CNT_W-1:0]  period_cnt_q, period_cnt_d;
    logic [CNT_W-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic [NCYC_W-1:0] cycles_q, cycles_d;
    logic              err_q, err_d;
    logic              start_q, start_d;
    logic              enter_start;
    logic              launch_w;
    logic              timeout_hit_w;
    logic              burst_done_w;
    logic [CNT_W:0]    tmo_next_w;

    // ------------------------------------------------------------------
    // Launch source
    // ------------------------------------------------------------------
`ifdef XTRIG_SCHED_EXT_TRIG_EN
    // [0],[1] form the synchroniser; [2] is the delayed copy for edge detect.
    logic [2:0] ext_sync_q;
    logic       ext_edge_w;
    logic       ext_drop_q;

    always_ff @(posedge ctrl_clk_i or negedge ctrl_rst_n_i) begin
        if (!ctrl_rst_n_i) begin
            ext_sync_q <= '0;
            ext_drop_q <= 1'b0;
        end else begin
            ext_sync_q <= {ext_sync_q[1:0], ext_trigger_i};
            if (ext_edge_w && busy_o) begin
                ext_drop_q <= 1'b1;
            end else if (err_clr_i) begin
                ext_drop_q <= 1'b0;
            end
        end
    end

    assign ext_edge_w      = ext_sync_q[1] & ~ext_sync_q[2];
    assign launch_w        = sw_trigger_i | ext_edge_w;
    assign ext_trig_drop_o = ext_drop_q;
`else
    assign launch_w = sw_trigger_i;
`endif

    // Timeout fires on the clock edge at which the counter would reach
    // timeout_i, so the error lands exactly timeout_i clocks after the
    // start edge. Extra bit keeps the compare safe at counter saturation.
    assign tmo_next_w    = {1'b0, tmo_cnt_q} + (CNT_W + 1)'(1);
    assign timeout_hit_w = (timeout_i != '0) && (tmo_next_w >= {1'b0, timeout_i});
    assign burst_done_w  = (num_cycles_i != '0) && (cycles_q >= num_cycles_i);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        pulse_cnt_d  = pulse_cnt_q;
        period_cnt_d = (period_cnt_q == '1) ? period_cnt_q : period_cnt_q + CNT_W'(1);
        tmo_cnt_d    = tmo_cnt_q;
        cycles_d     = cycles_q;
        err_d        = err_q & ~err_clr_i;
        enter_start  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // A trigger while the controller is still busy is dropped.
                if (sched_enable_i && launch_w && cycle_done_i) begin
                    state_d     = ST_START;
                    enter_start = 1'b1;
                    cycles_d    = '0;
                end
            end
            ST_START: begin
                if (timeout_hit_w) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end else if (pulse_cnt_q == LAST_PULSE) begin
                    state_d = ST_WAIT_ACK;
                end else begin
                    pulse_cnt_d = pulse_cnt_q + PW_W'(1);
                end
            end
            ST_WAIT_ACK: begin
                if (timeout_hit_w) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end else if (!cycle_done_i) begin
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (timeout_hit_w) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end else if (cycle_done_i) begin
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (!mode_i || !sched_enable_i || burst_done_w) begin
                    state_d = ST_IDLE;
                end else if (period_cnt_q >= period_i) begin
                    state_d     = ST_START;
                    enter_start = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if ((state_q == ST_START) || (state_q == ST_WAIT_ACK) || (state_q == ST_WAIT_DONE)) begin
            tmo_cnt_d = (tmo_cnt_q == '1) ? tmo_cnt_q : tmo_cnt_q + CNT_W'(1);
        end

        // Period counter reads 1 in the first START cycle so that a GAP exit
        // at count >= period_i spaces rising edges exactly period_i apart.
        if (enter_start) begin
            pulse_cnt_d  = '0;
            period_cnt_d = CNT_W'(1);
            tmo_cnt_d    = '0;
            cycles_d     = (cycles_d == '1) ? cycles_d : cycles_d + NCYC_W'(1);
        end
    end

    // Start pulse is a flop mirroring the next state, so a timeout in START
    // truncates it on the same edge.
    assign start_d = (state_d == ST_START);

    always_ff @(posedge ctrl_clk_i or negedge ctrl_rst_n_i) begin
        if (!ctrl_rst_n_i) begin
            state_q      <= ST_IDLE;
            pulse_cnt_q  <= '0;
            period_cnt_q <= '0;
            tmo_cnt_q    <= '0;
            cycles_q     <= '0;
            err_q        <= 1'b0;
            start_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pulse_cnt_q  <= pulse_cnt_d;
            period_cnt_q <= period_cnt_d;
            tmo_cnt_q    <= tmo_cnt_d;
            cycles_q     <= cycles_d;
            err_q        <= err_d;
            start_q      <= start_d;
        end
    end

    assign xtrig_cycle_start_o = start_q;
    assign busy_o              = (state_q != ST_IDLE);
    assign cycles_issued_o     = cycles_q;
    assign timeout_err_o       = err_q;
    assign state_o             = state_q;

endmodule
`default_nettype wire

// File: tb/tb_xtrig_cycle_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_xtrig_cycle_scheduler
// Description : Self-checking bench for xtrig_cycle_scheduler. Expected start
//               pulses (rise cycle, width) are queued when a trigger is
//               driven; a monitor queues the pulses the DUT actually emits
//               and each scenario task compares the two. A small controller
//               model drives cycle_done_i relative to each start rise.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_xtrig_cycle_scheduler;

    localparam int CNT_W  = 32;
    localparam int PW     = 4;
    localparam int NCYC_W = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              sched_enable;
    logic              mode;
    logic              sw_trigger;
    logic [CNT_W-1:0]  period;
    logic [NCYC_W-1:0] num_cycles;
    logic [CNT_W-1:0]  timeout;
    logic              cycle_done;
    logic              err_clr;
    logic              start;
    logic              busy;
    logic [NCYC_W-1:0] cycles_issued;
    logic              timeout_err;
    logic [2:0]        state;
`ifdef XTRIG_SCHED_EXT_TRIG_EN
    logic              ext_drop;
`endif

    xtrig_cycle_scheduler #(
        .CNT_W         (CNT_W),
        .START_PULSE_W (PW),
        .NCYC_W        (NCYC_W)
    ) dut (
        .ctrl_clk_i          (clk),
        .ctrl_rst_n_i        (rst_n),
        .sched_enable_i      (sched_enable),
        .mode_i              (mode),
        .sw_trigger_i        (sw_trigger),
        .period_i            (period),
        .num_cycles_i        (num_cycles),
        .timeout_i           (timeout),
        .cycle_done_i        (cycle_done),
        .err_clr_i           (err_clr),
`ifdef XTRIG_SCHED_EXT_TRIG_EN
        .ext_trigger_i       (1'b0),
        .ext_trig_drop_o     (ext_drop),
`endif
        .xtrig_cycle_start_o (start),
        .busy_o              (busy),
        .cycles_issued_o     (cycles_issued),
        .timeout_err_o       (timeout_err),
        .state_o             (state)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Scoreboard: expected pulses pushed by the tasks, observed by monitor.
    int exp_rise[$];
    int exp_w[$];
    int obs_rise[$];
    int obs_w[$];

    // Controller model: cycle_done_i drops drop_at clocks after a start rise
    // and rises again rise_at clocks after it (-1 = never).
    bit mdl_en  = 1'b0;
    int drop_at = 2;
    int rise_at = -1;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin : monitor
        bit in_pulse;
        int r;
        int w;
        in_pulse = 1'b0;
        r = 0;
        w = 0;
        forever begin
            @(negedge clk);
            if (start === 1'b1 && !in_pulse) begin
                in_pulse = 1'b1;
                r = cyc;
                w = 1;
            end else if (start === 1'b1) begin
                w++;
            end else if (in_pulse) begin
                in_pulse = 1'b0;
                obs_rise.push_back(r);
                obs_w.push_back(w);
            end
        end
    end

    initial begin : ctrl_model
        bit prev;
        int mc;
        prev = 1'b0;
        mc = 1000000;
        forever begin
            @(negedge clk);
            if (mdl_en) begin
                if (start === 1'b1 && !prev) mc = 0;
                else if (mc < 1000000) mc++;
                if (mc == drop_at) cycle_done = 1'b0;
                if (mc == rise_at) cycle_done = 1'b1;
            end
            prev = start;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic wait_to(input int x);
        while (cyc < x) @(negedge clk);
    endtask

    // Pulses sw_trigger for one cycle; t = cycle in which it was high.
    task automatic fire(output int t);
        sw_trigger = 1'b1;
        t = cyc;
        @(negedge clk);
        sw_trigger = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (start !== 1'b0) begin failures++; $display("FAIL rst_start got=%b exp=0", start); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
        checks++;
        if (cycles_issued !== '0) begin failures++; $display("FAIL rst_cycles got=%0d exp=0", cycles_issued); end
        checks++;
        if (timeout_err !== 1'b0) begin failures++; $display("FAIL rst_err got=%b exp=0", timeout_err); end
        checks++;
        if (state !== 3'd0) begin failures++; $display("FAIL rst_state got=%0d exp=0", state); end
    endtask

    task automatic test_single_shot();
        int t, er, ew, orr, ow;
        mode = 1'b0; timeout = '0; drop_at = 5; rise_at = 29; mdl_en = 1'b1;
        fire(t);
        exp_rise.push_back(t + 1); exp_w.push_back(PW);
        wait_to(t + 31);
        checks++;
        if (state !== 3'd4) begin failures++; $display("FAIL single_gap_state got=%0d exp=4", state); end
        wait_to(t + 32);
        checks++;
        if (state !== 3'd0) begin failures++; $display("FAIL single_idle_state got=%0d exp=0", state); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL single_busy got=%b exp=0", busy); end
        checks++;
        if (cycles_issued !== 16'd1) begin failures++; $display("FAIL single_cycles got=%0d exp=1", cycles_issued); end
        while (exp_rise.size() != 0) begin
            er = exp_rise.pop_front(); ew = exp_w.pop_front();
            orr = -1; ow = -1;
            if (obs_rise.size() != 0) begin orr = obs_rise.pop_front(); ow = obs_w.pop_front(); end
            checks++;
            if (orr !== er || ow !== ew) begin failures++; $display("FAIL single_pulse rise=%0d width=%0d exp rise=%0d width=%0d", orr, ow, er, ew); end
        end
        checks++;
        if (obs_rise.size() != 0) begin failures++; $display("FAIL single_extra got=%0d pulses exp=0", obs_rise.size()); obs_rise.delete(); obs_w.delete(); end
    endtask

    task automatic test_periodic();
        int t, r1, er, ew, orr, ow;
        mode = 1'b1; period = 100; num_cycles = 3; drop_at = 2; rise_at = 50; mdl_en = 1'b1;
        fire(t);
        r1 = t + 1;
        for (int k = 0; k < 3; k++) begin
            exp_rise.push_back(r1 + 100 * k); exp_w.push_back(PW);
        end
        wait_to(r1 + 260);
        checks++;
        if (state !== 3'd0) begin failures++; $display("FAIL periodic_state got=%0d exp=0", state); end
        checks++;
        if (cycles_issued !== 16'd3) begin failures++; $display("FAIL periodic_cycles got=%0d exp=3", cycles_issued); end
        while (exp_rise.size() != 0) begin
            er = exp_rise.pop_front(); ew = exp_w.pop_front();
            orr = -1; ow = -1;
            if (obs_rise.size() != 0) begin orr = obs_rise.pop_front(); ow = obs_w.pop_front(); end
            checks++;
            if (orr !== er || ow !== ew) begin failures++; $display("FAIL periodic_pulse rise=%0d width=%0d exp rise=%0d width=%0d", orr, ow, er, ew); end
        end
        checks++;
        if (obs_rise.size() != 0) begin failures++; $display("FAIL periodic_extra got=%0d pulses exp=0", obs_rise.size()); obs_rise.delete(); obs_w.delete(); end
    endtask

    task automatic test_back_to_back();
        int t, r1, er, ew, orr, ow;
        mode = 1'b1; period = 10; num_cycles = 2; drop_at = 2; rise_at = 60; mdl_en = 1'b1;
        fire(t);
        r1 = t + 1;
        exp_rise.push_back(r1);      exp_w.push_back(PW);
        exp_rise.push_back(r1 + 62); exp_w.push_back(PW);
        wait_to(r1 + 61);
        checks++;
        if (state !== 3'd4) begin failures++; $display("FAIL b2b_gap_state got=%0d exp=4", state); end
        wait_to(r1 + 135);
        checks++;
        if (state !== 3'd0) begin failures++; $display("FAIL b2b_state got=%0d exp=0", state); end
        checks++;
        if (cycles_issued !== 16'd2) begin failures++; $display("FAIL b2b_cycles got=%0d exp=2", cycles_issued); end
        while (exp_rise.size() != 0) begin
            er = exp_rise.pop_front(); ew = exp_w.pop_front();
            orr = -1; ow = -1;
            if (obs_rise.size() != 0) begin orr = obs_rise.pop_front(); ow = obs_w.pop_front(); end
            checks++;
            if (orr !== er || ow !== ew) begin failures++; $display("FAIL b2b_pulse rise=%0d width=%0d exp rise=%0d width=%0d", orr, ow, er, ew); end
        end
        checks++;
        if (obs_rise.size() != 0) begin failures++; $display("FAIL b2b_extra got=%0d pulses exp=0", obs_rise.size()); obs_rise.delete(); obs_w.delete(); end
    endtask

    task automatic test_timeout();
        int t, r, er, ew, orr, ow;
        mode = 1'b0; timeout = 200; drop_at = 2; rise_at = -1; mdl_en = 1'b1;
        // First timeout: plain set.
        fire(t);
        r = t + 1;
        exp_rise.push_back(r); exp_w.push_back(PW);
        wait_to(r + 199);
        checks++;
        if (timeout_err !== 1'b0 || state !== 3'd3) begin failures++; $display("FAIL tmo_early err=%b state=%0d exp err=0 state=3", timeout_err, state); end
        wait_to(r + 200);
        checks++;
        if (timeout_err !== 1'b1 || state !== 3'd0) begin failures++; $display("FAIL tmo_set err=%b state=%0d exp err=1 state=0", timeout_err, state); end
        // Clear.
        cycle_done = 1'b1;
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        checks++;
        if (timeout_err !== 1'b0) begin failures++; $display("FAIL tmo_clear got=%b exp=0", timeout_err); end
        // Second timeout with err_clr on the same edge: set must win.
        @(negedge clk);
        fire(t);
        r = t + 1;
        exp_rise.push_back(r); exp_w.push_back(PW);
        wait_to(r + 199);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        checks++;
        if (timeout_err !== 1'b1) begin failures++; $display("FAIL tmo_set_vs_clr got=%b exp=1", timeout_err); end
        cycle_done = 1'b1;
        timeout = '0;
        while (exp_rise.size() != 0) begin
            er = exp_rise.pop_front(); ew = exp_w.pop_front();
            orr = -1; ow = -1;
            if (obs_rise.size() != 0) begin orr = obs_rise.pop_front(); ow = obs_w.pop_front(); end
            checks++;
            if (orr !== er || ow !== ew) begin failures++; $display("FAIL tmo_pulse rise=%0d width=%0d exp rise=%0d width=%0d", orr, ow, er, ew); end
        end
    endtask

    task automatic test_disable_mid();
        int t, r1, er, ew, orr, ow;
        // timeout_err is still set here; the trigger must still be accepted.
        mode = 1'b1; period = 80; num_cycles = 0; drop_at = 2; rise_at = 30; mdl_en = 1'b1;
        @(negedge clk);
        fire(t);
        r1 = t + 1;
        exp_rise.push_back(r1);      exp_w.push_back(PW);
        exp_rise.push_back(r1 + 80); exp_w.push_back(PW);
        wait_to(r1 + 90);
        checks++;
        if (state !== 3'd3) begin failures++; $display("FAIL dis_wait_done got=%0d exp=3", state); end
        sched_enable = 1'b0;
        wait_to(r1 + 200);
        checks++;
        if (state !== 3'd0) begin failures++; $display("FAIL dis_state got=%0d exp=0", state); end
        checks++;
        if (cycles_issued !== 16'd2) begin failures++; $display("FAIL dis_cycles got=%0d exp=2", cycles_issued); end
        // Trigger while the controller reports busy: must be ignored.
        sched_enable = 1'b1;
        mdl_en = 1'b0;
        cycle_done = 1'b0;
        fire(t);
        wait_to(t + 10);
        checks++;
        if (state !== 3'd0 || busy !== 1'b0) begin failures++; $display("FAIL dis_ignored state=%0d busy=%b exp state=0 busy=0", state, busy); end
        cycle_done = 1'b1;
        while (exp_rise.size() != 0) begin
            er = exp_rise.pop_front(); ew = exp_w.pop_front();
            orr = -1; ow = -1;
            if (obs_rise.size() != 0) begin orr = obs_rise.pop_front(); ow = obs_w.pop_front(); end
            checks++;
            if (orr !== er || ow !== ew) begin failures++; $display("FAIL dis_pulse rise=%0d width=%0d exp rise=%0d width=%0d", orr, ow, er, ew); end
        end
        checks++;
        if (obs_rise.size() != 0) begin failures++; $display("FAIL dis_extra got=%0d pulses exp=0", obs_rise.size()); obs_rise.delete(); obs_w.delete(); end
    endtask

    task automatic test_reset_mid();
        int t, r, er, ew, orr, ow;
        mode = 1'b0; drop_at = 5; rise_at = 10; mdl_en = 1'b1;
        @(negedge clk);
        fire(t);
        r = t + 1;
        exp_rise.push_back(r); exp_w.push_back(2);
        wait_to(r + 1);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (start !== 1'b0) begin failures++; $display("FAIL rmid_start got=%b exp=0", start); end
        checks++;
        if (busy !== 1'b0 || state !== 3'd0) begin failures++; $display("FAIL rmid_state busy=%b state=%0d exp 0/0", busy, state); end
        checks++;
        if (cycles_issued !== '0 || timeout_err !== 1'b0) begin failures++; $display("FAIL rmid_status cycles=%0d err=%b exp 0/0", cycles_issued, timeout_err); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        fire(t);
        exp_rise.push_back(t + 1); exp_w.push_back(PW);
        wait_to(t + 30);
        checks++;
        if (state !== 3'd0 || cycles_issued !== 16'd1) begin failures++; $display("FAIL rmid_after state=%0d cycles=%0d exp 0/1", state, cycles_issued); end
        while (exp_rise.size() != 0) begin
            er = exp_rise.pop_front(); ew = exp_w.pop_front();
            orr = -1; ow = -1;
            if (obs_rise.size() != 0) begin orr = obs_rise.pop_front(); ow = obs_w.pop_front(); end
            checks++;
            if (orr !== er || ow !== ew) begin failures++; $display("FAIL rmid_pulse rise=%0d width=%0d exp rise=%0d width=%0d", orr, ow, er, ew); end
        end
        checks++;
        if (obs_rise.size() != 0) begin failures++; $display("FAIL rmid_extra got=%0d pulses exp=0", obs_rise.size()); obs_rise.delete(); obs_w.delete(); end
    endtask

    initial begin
        rst_n        = 1'b0;
        sched_enable = 1'b1;
        mode         = 1'b0;
        sw_trigger   = 1'b0;
        period       = '0;
        num_cycles   = '0;
        timeout      = '0;
        cycle_done   = 1'b1;
        err_clr      = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        test_single_shot();
        @(negedge clk);
        test_periodic();
        @(negedge clk);
        test_back_to_back();
        @(negedge clk);
        test_timeout();
        test_disable_mid();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
